lbr_record_ctrl: RTL and testbench

- Write-side controller for the Last Branch Record register file; sits directly upstream of it.
- Accepts retired-branch events from the core commit stage over a valid/ready handshake.
- Maintains the circular write pointer, entry count, elapsed-cycle counter and freeze/clear state.
- Drives the register file's three write ports so that FROM, TO and INFO for one branch land in the same cycle.

---
 rtl/lbr_record_ctrl_if.sv | 22 ++
 rtl/lbr_record_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lbr_record_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lbr_record_ctrl_if.sv
// Retired-branch event channel from the commit stage into the LBR write controller.
// The core side drives the event fields; the controller returns br_ready.
interface lbr_record_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  br_valid;
  logic                  br_ready;
  logic [DATA_WIDTH-1:0] br_from;
  logic [DATA_WIDTH-1:0] br_to;
  logic [2:0]            br_type;
  logic                  br_mispred;

  modport master (
    output br_valid, br_from, br_to, br_type, br_mispred,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_from, br_to, br_type, br_mispred,
    output br_ready
  );
endinterface

// File: rtl/lbr_record_ctrl.sv
// Write-side controller for the Last Branch Record register file: circular pointer,
// entry count, elapsed-cycle stamp, freeze-on-full and the clear sweep.
//
// state     | meaning
// ST_RUN    | events accepted; unmasked events written to FROM/TO/INFO banks
// ST_FROZEN | events accepted and dropped; elapsed counter keeps running
// ST_CLEAR  | zeroing one index per cycle across all three banks; no events taken
module lbr_record_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int LBR_SIZE   = 16,
  parameter int SEL_W      = $clog2(LBR_SIZE) + 2
) (
  input  logic                          clock,
  input  logic                          reset,
  lbr_record_ctrl_if.slave              br,
  input  logic [7:0]                    type_mask,
  input  logic                          freeze_on_full,
  input  logic                          clear_req,
  output logic                          wEn0,
  output logic                          wEn1,
  output logic                          wEn2,
  output logic [SEL_W-1:0]              write_sel0,
  output logic [SEL_W-1:0]              write_sel1,
  output logic [SEL_W-1:0]              write_sel2,
  output logic [DATA_WIDTH-1:0]         write_data0,
  output logic [DATA_WIDTH-1:0]         write_data1,
  output logic [DATA_WIDTH-1:0]         write_data2,
  output logic [$clog2(LBR_SIZE)-1:0]   tos,
  output logic [$clog2(LBR_SIZE):0]     count,
  output logic                          frozen,
  output logic                          busy
);

  localparam int IDX_W = $clog2(LBR_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LBR_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LBR_SIZE);
  localparam logic [1:0] BANK_FROM = 2'd0;
  localparam logic [1:0] BANK_TO   = 2'd1;
  localparam logic [1:0] BANK_INFO = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FROZEN = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]      tos_q, tos_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [15:0]           elapsed_q, elapsed_d;
  logic [IDX_W-1:0]      clr_idx_q, clr_idx_d;
  logic                  frozen_q, frozen_d;
  logic                  busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [SEL_W-1:0]      sel0_q, sel0_d, sel1_q, sel1_d, sel2_q, sel2_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d, data2_q, data2_d;

  logic                  ready_w;
  logic                  record_w;
  logic [15:0]           elapsed_inc;
  logic [IDX_W-1:0]      widx;
  logic [DATA_WIDTH-1:0] info_w;

  assign ready_w     = (state_q != ST_CLEAR) && !clear_req;
  assign br.br_ready = ready_w;
  assign record_w    = br.br_valid && ready_w && (state_q == ST_RUN) && type_mask[br.br_type];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    tos_d       = tos_q;
    count_d     = count_q;
    elapsed_d   = elapsed_q;
    clr_idx_d   = clr_idx_q;
    frozen_d    = frozen_q;
    busy_d      = busy_q;
    wen_d       = 1'b0;
    widx        = '0;
    sel0_d      = '0;
    sel1_d      = '0;
    sel2_d      = '0;
    data0_d     = '0;
    data1_d     = '0;
    data2_d     = '0;
    elapsed_inc = (elapsed_q == 16'hFFFF) ? elapsed_q : elapsed_q + 16'd1;

    info_w        = '0;
    info_w[15:0]  = elapsed_q;
    info_w[18:16] = br.br_type;
    info_w[19]    = br.br_mispred;

    unique case (state_q)
      ST_RUN, ST_FROZEN: begin
        elapsed_d = elapsed_inc;
        if (clear_req) begin
          state_d   = ST_CLEAR;
          busy_d    = 1'b1;
          clr_idx_d = '0;
          elapsed_d = '0;
          wen_d     = 1'b1;
          widx      = '0;
        end else if (record_w) begin
          wen_d     = 1'b1;
          widx      = wr_ptr_q;
          data0_d   = br.br_from;
          data1_d   = br.br_to;
          data2_d   = info_w;
          tos_d     = wr_ptr_q;
          wr_ptr_d  = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + IDX_W'(1);
          count_d   = (count_q == FULL_CNT) ? count_q : count_q + CNT_W'(1);
          // The stamp restarts from the accept cycle of the last recorded event.
          elapsed_d = 16'd1;
          if (freeze_on_full && (count_d == FULL_CNT)) begin
            state_d  = ST_FROZEN;
            frozen_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        elapsed_d = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d  = ST_RUN;
          busy_d   = 1'b0;
          frozen_d = 1'b0;
          wr_ptr_d = '0;
          tos_d    = LAST_IDX;
          count_d  = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
          wen_d     = 1'b1;
          widx      = clr_idx_d;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (wen_d) begin
      sel0_d = {BANK_FROM, widx};
      sel1_d = {BANK_TO,   widx};
      sel2_d = {BANK_INFO, widx};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      wr_ptr_q  <= '0;
      tos_q     <= LAST_IDX;
      count_q   <= '0;
      elapsed_q <= '0;
      clr_idx_q <= '0;
      frozen_q  <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      sel0_q    <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      tos_q     <= tos_d;
      count_q   <= count_d;
      elapsed_q <= elapsed_d;
      clr_idx_q <= clr_idx_d;
      frozen_q  <= frozen_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      sel0_q    <= sel0_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
    end
  end

  assign wEn0        = wen_q;
  assign wEn1        = wen_q;
  assign wEn2        = wen_q;
  assign write_sel0  = sel0_q;
  assign write_sel1  = sel1_q;
  assign write_sel2  = sel2_q;
  assign write_data0 = data0_q;
  assign write_data1 = data1_q;
  assign write_data2 = data2_q;
  assign tos         = tos_q;
  assign count       = count_q;
  assign frozen      = frozen_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lbr_record_ctrl.sv
// Bench for lbr_record_ctrl (LBR_SIZE=4): directed scenarios then random traffic,
// every cycle compared against a record-level model of the LBR write behaviour.
module tb_lbr_record_ctrl;
  localparam int DW = 64;
  localparam int L  = 4;
  localparam int IW = $clog2(L);
  localparam int SW = IW + 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [7:0] type_mask = 8'hFF;
  logic freeze_on_full = 1'b0;
  logic clear_req = 1'b0;
  logic wEn0, wEn1, wEn2;
  logic [SW-1:0] write_sel0, write_sel1, write_sel2;
  logic [DW-1:0] write_data0, write_data1, write_data2;
  logic [IW-1:0] tos;
  logic [IW:0]   count;
  logic frozen, busy;

  lbr_record_ctrl_if #(.DATA_WIDTH(DW)) bus();

  lbr_record_ctrl #(.DATA_WIDTH(DW), .LBR_SIZE(L)) dut (
    .clock(clock), .reset(reset), .br(bus),
    .type_mask(type_mask), .freeze_on_full(freeze_on_full), .clear_req(clear_req),
    .wEn0(wEn0), .wEn1(wEn1), .wEn2(wEn2),
    .write_sel0(write_sel0), .write_sel1(write_sel1), .write_sel2(write_sel2),
    .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
    .tos(tos), .count(count), .frozen(frozen), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  // Record-level model: pointer/count/freeze bookkeeping plus the expected write of the next cycle.
  int m_ptr, m_cnt, m_tos, clr_start, anchor;
  bit m_frz, e_w, e_busy;
  logic [63:0] e_sel [3];
  logic [63:0] e_dat [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("wen0", 64'(wEn0), 64'(e_w));
    chk("wen1", 64'(wEn1), 64'(e_w));
    chk("wen2", 64'(wEn2), 64'(e_w));
    if (e_w) begin
      chk("sel0", 64'(write_sel0), e_sel[0]);
      chk("sel1", 64'(write_sel1), e_sel[1]);
      chk("sel2", 64'(write_sel2), e_sel[2]);
      chk("data0", write_data0, e_dat[0]);
      chk("data1", write_data1, e_dat[1]);
      chk("data2", write_data2, e_dat[2]);
    end
    chk("tos", 64'(tos), 64'(m_tos));
    chk("count", 64'(count), 64'(m_cnt));
    chk("frozen", 64'(frozen), 64'(m_frz));
    chk("busy", 64'(busy), 64'(e_busy));
  endtask

  task automatic apply_reset();
    bus.br_valid = 1'b0;
    clear_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wen", {61'd0, wEn0, wEn1, wEn2}, 64'd0);
    chk("rst_sel2", 64'(write_sel2), 64'd0);
    chk("rst_data2", write_data2, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_tos", 64'(tos), 64'(L - 1));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_ptr = 0; m_cnt = 0; m_tos = L - 1; m_frz = 1'b0;
    clr_start = -1; anchor = cyc; e_busy = 1'b0; e_w = 1'b0;
  endtask

  // Called at a negedge: drives one cycle of inputs, predicts, then checks the next cycle.
  task automatic step(input bit v, input logic [63:0] f, input logic [63:0] t,
                      input logic [2:0] ty, input bit mp, input bit clr);
    int n, idx, el;
    bit clearing_now;
    n = cyc;
    bus.br_valid = v; bus.br_from = f; bus.br_to = t;
    bus.br_type = ty; bus.br_mispred = mp; clear_req = clr;
    #1;
    clearing_now = (clr_start >= 0) && (n >= clr_start) && (n < clr_start + L);
    chk("br_ready", 64'(bus.br_ready), 64'(!clearing_now && !clr));
    e_w = 1'b0; idx = 0;
    e_dat[0] = '0; e_dat[1] = '0; e_dat[2] = '0;
    if (clearing_now) begin
      if (n + 1 < clr_start + L) begin
        e_w = 1'b1; idx = n + 1 - clr_start; e_busy = 1'b1;
      end else begin
        e_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_tos = L - 1; m_frz = 1'b0;
        anchor = n + 1; clr_start = -1;
      end
    end else if (clr) begin
      clr_start = n + 1; e_w = 1'b1; idx = 0; e_busy = 1'b1;
    end else if (v && type_mask[ty] && !m_frz) begin
      el = n - anchor;
      if (el > 65535) el = 65535;
      e_w = 1'b1; idx = m_ptr;
      e_dat[0] = f; e_dat[1] = t;
      e_dat[2] = {44'd0, mp, ty, el[15:0]};
      m_tos = m_ptr;
      m_ptr = (m_ptr + 1) % L;
      m_cnt = (m_cnt < L) ? m_cnt + 1 : L;
      if (freeze_on_full && m_cnt == L) m_frz = 1'b1;
      anchor = n;
    end
    for (int b = 0; b < 3; b++) e_sel[b] = 64'(b * (1 << IW) + idx);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic rand_event(input logic [2:0] ty);
    step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, ty, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    bus.br_valid = 1'b0; bus.br_from = '0; bus.br_to = '0;
    bus.br_type = '0; bus.br_mispred = 1'b0;

    // First event right after reset: elapsed stamp 0, mispred in bit 19.
    apply_reset();
    step(1'b1, 64'h100, 64'h200, 3'd0, 1'b1, 1'b0);
    chk("first_sel0", 64'(write_sel0), 64'h0);
    chk("first_sel1", 64'(write_sel1), 64'h4);
    chk("first_sel2", 64'(write_sel2), 64'h8);
    chk("first_info", write_data2, 64'h80000);
    idle();
    chk("first_tos", 64'(tos), 64'd0);
    chk("first_count", 64'(count), 64'd1);

    // Wrap without freeze.
    apply_reset();
    freeze_on_full = 1'b0;
    for (int i = 0; i < 6; i++) rand_event(3'($urandom_range(0, 7)));
    idle();
    chk("wrap_tos", 64'(tos), 64'd1);
    chk("wrap_count", 64'(count), 64'd4);
    chk("wrap_frozen", 64'(frozen), 64'd0);

    // Freeze on full: 5th event accepted but not written.
    apply_reset();
    freeze_on_full = 1'b1;
    for (int i = 0; i < 5; i++) rand_event(3'd1);
    chk("frz_nowen", 64'(wEn0), 64'd0);
    chk("frz_frozen", 64'(frozen), 64'd1);
    chk("frz_tos", 64'(tos), 64'd3);
    freeze_on_full = 1'b0;
    idle();
    chk("frz_sticky", 64'(frozen), 64'd1);

    // Clear from FROZEN together with a valid event.
    step(1'b1, 64'h55, 64'h66, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < L; i++) idle();
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_tos", 64'(tos), 64'd3);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_frozen", 64'(frozen), 64'd0);
    rand_event(3'd2);

    // Reset in the middle of a sweep.
    step(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b1);
    idle();
    #2;
    apply_reset();

    // Elapsed saturation, then reload to 1 on the next back-to-back record.
    for (int i = 0; i < 70000; i++) idle();
    rand_event(3'd3);
    chk("sat_info", 64'(write_data2[15:0]), 64'hFFFF);
    rand_event(3'd4);
    chk("reload_info", 64'(write_data2[15:0]), 64'd1);

    // Masked event neither writes nor restarts the elapsed stamp.
    apply_reset();
    type_mask = 8'h01;
    idle();
    idle();
    rand_event(3'd4);
    chk("mask_nowen", 64'(wEn0), 64'd0);
    rand_event(3'd0);
    chk("mask_sel0", 64'(write_sel0), 64'd0);
    chk("mask_elapsed", 64'(write_data2[15:0]), 64'd3);

    // Random traffic.
    apply_reset();
    type_mask = 8'hFF;
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) type_mask = 8'($urandom);
      if (i % 150 == 0) freeze_on_full = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 9) < 7), {$urandom, $urandom}, {$urandom, $urandom},
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
